// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int   GRP_W  = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_grp(input int width);
    return width / GRP_W;
  endfunction

  // Returns {P, G} for one 4-bit lookahead group.
  function automatic logic [1:0] group_pg(input logic [GRP_W-1:0] a, input logic [GRP_W-1:0] b);
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    p = a ^ b;
    g = a & b;
    return {&p, g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational 4-bit augmented lookahead group: sum bits plus group propagate/generate.
module cla_group
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             c,
  output logic [GRP_W-1:0] s,
  output logic             P,
  output logic             G
);

  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] cc;

  assign p = a ^ b;
  assign g = a & b;

  assign cc[0] = c;
  assign cc[1] = g[0] | (p[0] & c);
  assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
  assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);

  assign s      = p ^ cc;
  assign {P, G} = group_pg(a, b);

endmodule

// File: rtl/cla_pipe_adder.sv
// 3-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             Pout,
  output logic             Gout
);

  localparam int NG = num_grp(WIDTH);

  if (GRP != GRP_W || (WIDTH % GRP) != 0 || WIDTH < 4) begin : g_bad_param
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 (>= 4) and GRP must be 4");
  end

  logic             v0, v1, v2;
  logic             en0, en1, en2;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             c0, c1;
  logic [NG-1:0]    gp_n, gg_n, gp1, gg1;
  logic [NG-1:0]    ip, ig;
  logic [NG:0]      gc, gw;
  logic [WIDTH-1:0] s_w;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign en2      = !v2 || out_ready;
  assign en1      = !v1 || en2;
  assign en0      = !v0 || en1;
  assign in_ready = en0;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
      c0 <= 1'b0;
    end else if (en0) begin
      v0 <= in_valid;
      if (in_valid) begin
        a0 <= A;
        b0 <= (sub == OP_SUB) ? ~B : B;
        c0 <= (sub == OP_ADD) ? cin : 1'b1;
      end
    end
  end

  always_comb begin
    gp_n = '0;
    gg_n = '0;
    for (int k = 0; k < NG; k++)
      {gp_n[k], gg_n[k]} = group_pg(a0[k*GRP_W +: GRP_W], b0[k*GRP_W +: GRP_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      c1  <= 1'b0;
      gp1 <= '0;
      gg1 <= '0;
    end else if (en1) begin
      v1 <= v0;
      if (v0) begin
        a1  <= a0;
        b1  <= b0;
        c1  <= c0;
        gp1 <= gp_n;
        gg1 <= gg_n;
      end
    end
  end

  // Group carries ripple across groups from the registered P/G; gw is the cin=0 chain.
  always_comb begin
    gc    = '0;
    gw    = '0;
    gc[0] = c1;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg1[k] | (gp1[k] & gc[k]);
      gw[k+1] = ig[k] | (ip[k] & gw[k]);
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group u_grp (
      .a(a1[gi*GRP_W +: GRP_W]),
      .b(b1[gi*GRP_W +: GRP_W]),
      .c(gc[gi]),
      .s(s_w[gi*GRP_W +: GRP_W]),
      .P(ip[gi]),
      .G(ig[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
      Pout <= 1'b0;
      Gout <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        sum  <= s_w;
        cout <= gc[NG];
        ovf  <= (a1[WIDTH-1] == b1[WIDTH-1]) && (s_w[WIDTH-1] != a1[WIDTH-1]);
        zero <= ~|s_w;
        Pout <= &ip;
        Gout <= gw[NG];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector bench for cla_pipe_adder: single-beat table, backpressured stream, mid-flight reset.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, ovf, zero, Pout, Gout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        pout;
    logic        gout;
  } vec_t;

  cla_pipe_adder #(.WIDTH(16), .GRP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .Pout(Pout), .Gout(Gout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One beat with free-flowing output: checks acceptance, 3-cycle latency and all result fields.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    A = v.a; B = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check_output("in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 check_output("latency_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check_output("out_valid", 32'(out_valid), 32'd1);
    check_output("sum", 32'(sum), 32'(v.sum));
    check_output("cout", 32'(cout), 32'(v.cout));
    check_output("ovf", 32'(ovf), 32'(v.ovf));
    check_output("zero", 32'(zero), 32'(v.zero));
    check_output("Pout", 32'(Pout), 32'(v.pout));
    check_output("Gout", 32'(Gout), 32'(v.gout));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_flags"}, {27'd0, cout, ovf, zero, Pout, Gout}, 32'd0);
    check_output({tag, "_sum"}, 32'(sum), 32'd0);
  endtask

  vec_t vecs[10];

  logic [15:0] st_a[8], st_b[8], st_sum[8];
  logic        st_cin[8], st_sub[8], st_cout[8];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          a         b         cin   sub   sum       cout  ovf   zero  pout  gout
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      logic [16:0] full;
      logic [15:0] beff;
      st_a[i]   = 16'(16'h2222 * i + 16'h0F0F);
      st_b[i]   = 16'h1357 ^ 16'(i << 4);
      st_sub[i] = i[0];
      st_cin[i] = i[1];
      beff      = st_sub[i] ? ~st_b[i] : st_b[i];
      full      = {1'b0, st_a[i]} + {1'b0, beff} + 17'(st_sub[i] ? 1'b1 : st_cin[i]);
      st_sum[i] = full[15:0];
      st_cout[i] = full[16];
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

    // Back-to-back stream against an out_ready pattern of 1,0,0,1.
    begin
      int sent = 0, got = 0, occ = 0, cyc = 0;
      logic pat[4];
      logic acc, drn;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (got < 8 && cyc < 80) begin
        @(negedge clk);
        out_ready = pat[cyc % 4];
        if (sent < 8) begin
          in_valid = 1'b1;
          A = st_a[sent]; B = st_b[sent]; cin = st_cin[sent]; sub = st_sub[sent];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        check_output("stream_in_ready", 32'(in_ready), 32'(!(occ == 3 && !out_ready)));
        if (out_valid) begin
          check_output("stream_sum", 32'(sum), 32'(st_sum[got]));
          check_output("stream_cout", 32'(cout), 32'(st_cout[got]));
        end
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (acc) sent++;
        if (drn) got++;
        occ = occ + int'(acc) - int'(drn);
        cyc++;
      end
      check_output("stream_count", 32'(got), 32'd8);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        #1 check_output("stream_no_extra", 32'(out_valid), 32'd0);
      end
    end

    // Three beats in flight, then a one-cycle reset with in_valid held high.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = st_a[i]; B = st_b[i]; cin = st_cin[i]; sub = st_sub[i];
    end
    @(negedge clk);
    rst = 1'b1;
    A = 16'h1111; B = 16'h2222;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 check_all_zero("midreset");
    repeat (5) begin
      @(negedge clk);
      #1 check_output("post_reset_quiet", 32'(out_valid), 32'd0);
    end

    apply_stimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
